// File: rtl/decode_pipe.sv
// -----------------------------------------------------------------------------
// decode_pipe
//   Single-stage instruction decode with a valid/ready handshake on both sides.
//   An accepted instruction is decoded, has its condition evaluated against the
//   flags presented in the same cycle, and appears on registered outputs one
//   cycle later. Instructions that follow an executed branch are squashed for
//   FLUSH_SLOTS accepts.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst, inst_valid           instruction word and its valid
//   inst_ready                 stage can accept inst this cycle (combinational)
//   Z_flag/N_flag/C_flag/V_flag condition flags sampled at accept
//   out_valid, out_ready       decoded bundle valid / downstream takes it
//   inst_type                  BRANCH_INST/DATA_INST/LOAD_INST/STORE_INST
//   read_rega, read_regb       source register specifiers
//   write_reg                  destination register specifier
//   exec                       condition passed, legal and not squashed
//   reg_wr_en, mem_wr_en       write enables, gated by exec
//   illegal                    unrecognised code field
//   squash_cnt                 remaining squash slots
// -----------------------------------------------------------------------------
module decode_pipe #(
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned LINK_REG    = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           inst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic                  Z_flag,
    input  logic                  N_flag,
    input  logic                  C_flag,
    input  logic                  V_flag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            inst_type,
    output logic [REG_ADDR_W-1:0] read_rega,
    output logic [REG_ADDR_W-1:0] read_regb,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic                  exec,
    output logic                  reg_wr_en,
    output logic                  mem_wr_en,
    output logic                  illegal,
    output logic [2:0]            squash_cnt
);

    localparam logic [1:0] BRANCH_INST = 2'd0;
    localparam logic [1:0] DATA_INST   = 2'd1;
    localparam logic [1:0] LOAD_INST   = 2'd2;
    localparam logic [1:0] STORE_INST  = 2'd3;

    localparam logic [2:0]            FLUSH_LOAD = 3'(FLUSH_SLOTS);
    localparam logic [REG_ADDR_W-1:0] LINK_ADDR  = REG_ADDR_W'(LINK_REG);

    // ARM condition-code evaluation
    function automatic logic cond_pass_f(input logic [3:0] cond,
                                         input logic z, input logic n,
                                         input logic c, input logic v);
        logic pass;
        case (cond)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c && !z;
            4'h9:    pass = !c || z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z && (n == v);
            4'hD:    pass = z || (n != v);
            4'hE:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    logic                  out_valid_q,  out_valid_d;
    logic [1:0]            inst_type_q,  inst_type_d;
    logic [REG_ADDR_W-1:0] read_rega_q,  read_rega_d;
    logic [REG_ADDR_W-1:0] read_regb_q,  read_regb_d;
    logic [REG_ADDR_W-1:0] write_reg_q,  write_reg_d;
    logic                  exec_q,       exec_d;
    logic                  reg_wr_en_q,  reg_wr_en_d;
    logic                  mem_wr_en_q,  mem_wr_en_d;
    logic                  illegal_q,    illegal_d;
    logic [2:0]            squash_cnt_q, squash_cnt_d;

    logic                  accept_s;
    logic [1:0]            dec_type_s;
    logic                  dec_illegal_s;
    logic [REG_ADDR_W-1:0] dec_regb_s;
    logic [REG_ADDR_W-1:0] dec_wr_s;
    logic                  dec_exec_s;
    logic                  dec_rwe_s;
    logic                  dec_mwe_s;

    // Fields that this decoder does not interpret
    logic unused_bits_s;
    assign unused_bits_s = ^{inst[23:21], inst[11:4]};

    assign inst_ready = !out_valid_q || out_ready;
    assign accept_s   = inst_valid && inst_ready;

    // Decode the presented instruction word
    always_comb begin
        dec_type_s    = DATA_INST;
        dec_illegal_s = 1'b0;
        case (inst[27:25])
            3'b101:        dec_type_s = BRANCH_INST;
            3'b000,
            3'b001:        dec_type_s = DATA_INST;
            3'b010: begin
                if (inst[20]) begin
                    dec_type_s = LOAD_INST;
                end else begin
                    dec_type_s = STORE_INST;
                end
            end
            default: begin
                dec_type_s    = DATA_INST;
                dec_illegal_s = 1'b1;
            end
        endcase

        // Stores read their data register from the Rd field
        if (dec_type_s == STORE_INST) begin
            dec_regb_s = REG_ADDR_W'(inst[15:12]);
        end else begin
            dec_regb_s = REG_ADDR_W'(inst[3:0]);
        end

        if (dec_type_s == BRANCH_INST) begin
            dec_wr_s = LINK_ADDR;
        end else begin
            dec_wr_s = REG_ADDR_W'(inst[15:12]);
        end

        dec_exec_s = cond_pass_f(inst[31:28], Z_flag, N_flag, C_flag, V_flag)
                     && !dec_illegal_s && (squash_cnt_q == 3'd0);
        dec_rwe_s  = dec_exec_s && ((dec_type_s == DATA_INST) ||
                                    (dec_type_s == LOAD_INST) ||
                                    ((dec_type_s == BRANCH_INST) && inst[24]));
        dec_mwe_s  = dec_exec_s && (dec_type_s == STORE_INST);
    end

    // Next bundle, handshake and squash counter
    always_comb begin
        out_valid_d  = out_valid_q;
        inst_type_d  = inst_type_q;
        read_rega_d  = read_rega_q;
        read_regb_d  = read_regb_q;
        write_reg_d  = write_reg_q;
        exec_d       = exec_q;
        reg_wr_en_d  = reg_wr_en_q;
        mem_wr_en_d  = mem_wr_en_q;
        illegal_d    = illegal_q;
        squash_cnt_d = squash_cnt_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            inst_type_d = dec_type_s;
            read_rega_d = REG_ADDR_W'(inst[19:16]);
            read_regb_d = dec_regb_s;
            write_reg_d = dec_wr_s;
            exec_d      = dec_exec_s;
            reg_wr_en_d = dec_rwe_s;
            mem_wr_en_d = dec_mwe_s;
            illegal_d   = dec_illegal_s;
            // Only an executed branch (never a squashed one) arms the squash window
            if (dec_exec_s && (dec_type_s == BRANCH_INST)) begin
                squash_cnt_d = FLUSH_LOAD;
            end else if (squash_cnt_q != 3'd0) begin
                squash_cnt_d = squash_cnt_q - 3'd1;
            end else begin
                squash_cnt_d = squash_cnt_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            inst_type_q  <= DATA_INST;
            read_rega_q  <= '0;
            read_regb_q  <= '0;
            write_reg_q  <= '0;
            exec_q       <= 1'b0;
            reg_wr_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            illegal_q    <= 1'b0;
            squash_cnt_q <= 3'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            inst_type_q  <= inst_type_d;
            read_rega_q  <= read_rega_d;
            read_regb_q  <= read_regb_d;
            write_reg_q  <= write_reg_d;
            exec_q       <= exec_d;
            reg_wr_en_q  <= reg_wr_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            illegal_q    <= illegal_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign inst_type  = inst_type_q;
    assign read_rega  = read_rega_q;
    assign read_regb  = read_regb_q;
    assign write_reg  = write_reg_q;
    assign exec       = exec_q;
    assign reg_wr_en  = reg_wr_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign illegal    = illegal_q;
    assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_pipe
//   Scoreboard bench for decode_pipe (FLUSH_SLOTS=2). The driver computes the
//   expected bundle of every accepted instruction from a behavioural model and
//   queues it; a monitor compares the queue head against the DUT whenever a
//   bundle is presented and pops it when downstream takes it.
// -----------------------------------------------------------------------------
module tb_decode_pipe;

    localparam int FLUSH = 2;
    localparam logic [1:0] T_BR = 2'd0, T_DATA = 2'd1, T_LOAD = 2'd2, T_STORE = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = 32'd0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        Z_flag = 1'b0, N_flag = 1'b0, C_flag = 1'b0, V_flag = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  inst_type;
    logic [3:0]  read_rega, read_regb, write_reg;
    logic        exec, reg_wr_en, mem_wr_en, illegal;
    logic [2:0]  squash_cnt;

    decode_pipe #(.FLUSH_SLOTS(FLUSH), .REG_ADDR_W(4), .LINK_REG(14)) dut (
        .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .Z_flag(Z_flag), .N_flag(N_flag),
        .C_flag(C_flag), .V_flag(V_flag), .out_valid(out_valid),
        .out_ready(out_ready), .inst_type(inst_type), .read_rega(read_rega),
        .read_regb(read_regb), .write_reg(write_reg), .exec(exec),
        .reg_wr_en(reg_wr_en), .mem_wr_en(mem_wr_en), .illegal(illegal),
        .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] t;
        logic [3:0] ra, rb, wr;
        logic       ex, rwe, mwe, ill;
        logic [2:0] sq;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cnt = 0;      // model squash slots remaining
    bit   m_ov  = 1'b0;   // model: bundle held
    bit   run   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Condition from the ARM table: pairs share a base test, odd codes invert it
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Expected bundle for an accepted instruction; advances the model squash count
    function automatic exp_t model(input logic [31:0] i, input logic [3:0] f);
        exp_t e;
        e.ill = 1'b0;
        e.t   = T_DATA;
        if (i[27:25] == 3'b101) e.t = T_BR;
        else if (i[27:26] == 2'b00) e.t = T_DATA;
        else if (i[27:25] == 3'b010) e.t = i[20] ? T_LOAD : T_STORE;
        else e.ill = 1'b1;
        e.ra  = i[19:16];
        e.rb  = (e.t == T_STORE) ? i[15:12] : i[3:0];
        e.wr  = (e.t == T_BR) ? 4'd14 : i[15:12];
        e.ex  = cond_ok(i[31:28], f) && !e.ill && (m_cnt == 0);
        e.rwe = e.ex && (e.t == T_DATA || e.t == T_LOAD || (e.t == T_BR && i[24]));
        e.mwe = e.ex && (e.t == T_STORE);
        if (e.ex && e.t == T_BR) m_cnt = FLUSH;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
        e.sq = 3'(m_cnt);
        return e;
    endfunction

    // One cycle of stimulus; f = {N,Z,C,V}
    task automatic drive(input logic v, input logic [31:0] i, input logic [3:0] f, input logic r);
        bit exp_rdy;
        inst_valid = v;
        inst = i;
        {N_flag, Z_flag, C_flag, V_flag} = f;
        out_ready = r;
        @(negedge clk);
        exp_rdy = !m_ov || r;
        check("inst_ready", 32'(inst_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            q.push_back(model(i, f));
            m_ov = 1'b1;
        end else if (r) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles, input logic v, input logic [31:0] i);
        reset = 1'b1;
        inst_valid = v;
        inst = i;
        out_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        inst_valid = 1'b0;
        q.delete();
        m_cnt = 0;
        m_ov = 1'b0;
    endtask

    // Monitor: compare the presented bundle with the scoreboard head
    always @(negedge clk) begin
        if (run && !reset && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bundle: out_valid=1 with nothing expected");
            end else begin
                check("bundle",
                      32'({inst_type, read_rega, read_regb, write_reg, exec, reg_wr_en,
                           mem_wr_en, illegal, squash_cnt}),
                      32'({q[0].t, q[0].ra, q[0].rb, q[0].wr, q[0].ex, q[0].rwe,
                           q[0].mwe, q[0].ill, q[0].sq}));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic check_reset_state();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_squash", 32'(squash_cnt), 32'd0);
        check("rst_enables", 32'({exec, reg_wr_en, mem_wr_en, illegal}), 32'd0);
        check("rst_type", 32'(inst_type), 32'(T_DATA));
        check("rst_regs", 32'({read_rega, read_regb, write_reg}), 32'd0);
        check("rst_ready", 32'(inst_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset(2, 1'b0, 32'd0);
        check_reset_state();
        run = 1'b1;

        // ADD r1,r2,r3
        drive(1'b1, 32'hE0821003, 4'b0000, 1'b1);
        // BL then three ADDs: two squashed, third executes
        drive(1'b1, 32'hEB000004, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, 32'hE0821003, 4'b0000, 1'b1);
        drive(1'b0, 32'd0, 4'b0000, 1'b1);

        // STR held for three stalled cycles, second inst taken on release
        drive(1'b1, 32'hE5865000, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, 32'hE0821003, 4'b0000, 1'b0);
        drive(1'b1, 32'hE0821003, 4'b0000, 1'b1);
        drive(1'b0, 32'd0, 4'b0000, 1'b1);

        // LE branch passing, drain squash, LE branch failing
        drive(1'b1, 32'hDA000000, 4'b0100, 1'b1);
        drive(1'b1, 32'hE0821003, 4'b0000, 1'b1);
        drive(1'b1, 32'hE0821003, 4'b0000, 1'b1);
        drive(1'b1, 32'hDA000000, 4'b0000, 1'b1);
        // Illegal code
        drive(1'b1, 32'hE7000000, 4'b0000, 1'b1);
        drive(1'b0, 32'd0, 4'b0000, 1'b1);

        // Reset while squash_cnt=1, with a simultaneous valid instruction
        drive(1'b1, 32'hEB000004, 4'b0000, 1'b1);
        drive(1'b1, 32'hE0821003, 4'b0000, 1'b1);
        check("pre_reset_squash", 32'(squash_cnt), 32'd1);
        do_reset(1, 1'b1, 32'hE0821003);
        check_reset_state();

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            logic [31:0] ri;
            ri = $urandom;
            if ($urandom_range(0, 3) == 0) ri[27:25] = 3'b101;
            if ($urandom_range(0, 3) == 0) ri[31:28] = 4'hE;
            drive($urandom_range(0, 3) != 0, ri, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
        end

        // Drain and confirm every expected bundle was presented
        for (int k = 0; k < 4; k++) drive(1'b0, 32'd0, 4'b0000, 1'b1);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
